hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Sits beside the IF/ID and ID/EX

---
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, redirect flushes, fetch-miss and dmem-busy freezes.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [RW-1:0]    id_rs_i,
  input  logic [RW-1:0]    id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [RW-1:0]    ex_rt_i,
  input  logic             redirect_i,
  input  logic             imem_valid_i,
  input  logic             dmem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_hold_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_lu_done;
  logic   w_next_lu_done;

  logic   w_lu;
  logic   w_lu_eff;
  logic   w_pc_write;
  logic   w_hold;
  logic   w_flush;
  logic   w_bubble;
  logic   w_freeze;

  assign w_lu = ex_memread_i && (ex_rt_i != '0) &&
                ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  // The held ID instruction still matches the load for one more cycle after the
  // bubble is inserted; r_lu_done keeps that from being treated as a second hazard.
  assign w_lu_eff = w_lu && !r_lu_done;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    w_pc_write     = 1'b0;
    w_hold         = 1'b0;
    w_flush        = 1'b0;
    w_bubble       = 1'b0;
    w_freeze       = 1'b0;
    w_next_state   = r_state;
    w_next_lu_done = r_lu_done;

    if (dmem_busy_i) begin
      w_freeze = 1'b1;
      w_hold   = 1'b1;
    end else if (r_state == DRAIN) begin
      w_flush        = 1'b1;
      w_next_lu_done = 1'b0;
      if (imem_valid_i) w_next_state = RUN;
    end else if (w_lu_eff) begin
      w_hold         = 1'b1;
      w_bubble       = 1'b1;
      w_next_lu_done = 1'b1;
    end else if (redirect_i) begin
      w_pc_write     = 1'b1;
      w_flush        = 1'b1;
      w_next_lu_done = 1'b0;
      w_next_state   = (r_state == IMISS && !imem_valid_i) ? DRAIN : RUN;
    end else if (!imem_valid_i) begin
      w_flush        = 1'b1;
      w_next_lu_done = 1'b0;
      w_next_state   = IMISS;
    end else begin
      w_pc_write     = 1'b1;
      w_next_lu_done = 1'b0;
      w_next_state   = RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= RUN;
      r_lu_done <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_lu_done <= w_next_lu_done;
    end
  end

  // While reset is asserted the IF/ID register is forced to NOP and the PC held.
  assign pc_write_o    = rst_i && w_pc_write;
  assign ifid_hold_o   = rst_i && w_hold;
  assign ifid_flush_o  = !rst_i || w_flush;
  assign idex_bubble_o = rst_i && w_bubble;
  assign freeze_o      = rst_i && w_freeze;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_write_o && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (ifid_flush_o && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle vector table plus reset/counter sequences.
module tb_hazard_ctrl;

  localparam int RW    = 5;
  localparam int CNT_W = 4;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [RW-1:0]    id_rs_i, id_rt_i, ex_rt_i;
  logic             id_uses_rt_i, ex_memread_i, redirect_i, imem_valid_i, dmem_busy_i;
  logic             pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, freeze_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.RW(RW), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_uses_rt_i (id_uses_rt_i),
    .ex_memread_i (ex_memread_i),
    .ex_rt_i      (ex_rt_i),
    .redirect_i   (redirect_i),
    .imem_valid_i (imem_valid_i),
    .dmem_busy_i  (dmem_busy_i),
    .pc_write_o   (pc_write_o),
    .ifid_hold_o  (ifid_hold_o),
    .ifid_flush_o (ifid_flush_o),
    .idex_bubble_o(idex_bubble_o),
    .freeze_o     (freeze_o),
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  // exp bit order: {pc_write, hold, flush, bubble, freeze}
  typedef struct {
    string         name;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          uses_rt;
    logic          memrd;
    logic [RW-1:0] ex_rt;
    logic          redir;
    logic          valid;
    logic          busy;
    logic [4:0]    exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_m = 0;
  int   flush_m = 0;

  function automatic logic [4:0] outs();
    return {pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, freeze_o};
  endfunction

  function automatic int sat(int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(string name, int rs, int rt, bit uses_rt, bit memrd, int ex_rt,
                     bit redir, bit valid, bit busy, logic [4:0] exp);
    vec_t v;
    v.name = name; v.rs = RW'(rs); v.rt = RW'(rt); v.uses_rt = uses_rt;
    v.memrd = memrd; v.ex_rt = RW'(ex_rt); v.redir = redir; v.valid = valid;
    v.busy = busy; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(vec_t v);
    id_rs_i = v.rs; id_rt_i = v.rt; id_uses_rt_i = v.uses_rt; ex_memread_i = v.memrd;
    ex_rt_i = v.ex_rt; redirect_i = v.redir; imem_valid_i = v.valid; dmem_busy_i = v.busy;
  endtask

  task automatic set_simple(bit redir, bit valid);
    id_rs_i = 5'd1; id_rt_i = 5'd2; id_uses_rt_i = 1'b1; ex_memread_i = 1'b0;
    ex_rt_i = 5'd0; redirect_i = redir; imem_valid_i = valid; dmem_busy_i = 1'b0;
  endtask

  task automatic check_counters(string name);
    check({name, "_stall_cnt"}, 32'(stall_cnt_o), PERF ? 32'(sat(stall_m)) : 32'd0);
    check({name, "_flush_cnt"}, 32'(flush_cnt_o), PERF ? 32'(sat(flush_m)) : 32'd0);
  endtask

  task automatic check_reset_outs(string name);
    check({name, "_outs"}, 32'(outs()), 32'(5'b00100));
    check({name, "_stall_cnt"}, 32'(stall_cnt_o), 32'd0);
    check({name, "_flush_cnt"}, 32'(flush_cnt_o), 32'd0);
  endtask

  always @(negedge clk_i) begin
    if (rst_i === 1'b1) begin
      check("inv_hold_flush", 32'(ifid_hold_o & ifid_flush_o), 32'd0);
      check("inv_bubble_hold", 32'(idex_bubble_o & ~ifid_hold_o), 32'd0);
      check("inv_freeze_bubble", 32'(freeze_o & idex_bubble_o), 32'd0);
    end
  end

  initial begin
    // Load-use and its corner cases
    add("idle",          1, 2, 1, 0, 0, 0, 1, 0, 5'b10000);
    add("lu_stall",      5, 2, 1, 1, 5, 0, 1, 0, 5'b01010);
    add("lu_once",       5, 2, 1, 1, 5, 0, 1, 0, 5'b10000);
    add("lu_clear",      5, 2, 1, 0, 5, 0, 1, 0, 5'b10000);
    add("rt0_no_lu",     0, 0, 1, 1, 0, 0, 1, 0, 5'b10000);
    add("rt_unused",     1, 7, 0, 1, 7, 0, 1, 0, 5'b10000);
    add("rt_used_lu",    1, 7, 1, 1, 7, 0, 1, 0, 5'b01010);
    add("rt_used_once",  1, 7, 1, 0, 7, 0, 1, 0, 5'b10000);
    // Redirect in RUN
    add("redir_run",     1, 2, 1, 0, 0, 1, 1, 0, 5'b10100);
    add("after_redir",   1, 2, 1, 0, 0, 0, 1, 0, 5'b10000);
    add("redir_novalid", 1, 2, 1, 0, 0, 1, 0, 0, 5'b10100);
    add("after_redir2",  1, 2, 1, 0, 0, 0, 1, 0, 5'b10000);
    // Miss, redirect while missing -> DRAIN
    add("miss1",         1, 2, 1, 0, 0, 0, 0, 0, 5'b00100);
    add("miss_redir",    1, 2, 1, 0, 0, 1, 0, 0, 5'b10100);
    add("drain_wait",    1, 2, 1, 0, 0, 0, 0, 0, 5'b00100);
    add("drain_done",    1, 2, 1, 0, 0, 0, 1, 0, 5'b00100);
    add("drain_run",     1, 2, 1, 0, 0, 0, 1, 0, 5'b10000);
    // IMISS -> RUN, and redirect in IMISS with valid data
    add("miss2",         1, 2, 1, 0, 0, 0, 0, 0, 5'b00100);
    add("miss_return",   1, 2, 1, 0, 0, 0, 1, 0, 5'b10000);
    add("miss3",         1, 2, 1, 0, 0, 0, 0, 0, 5'b00100);
    add("miss_redir_v",  1, 2, 1, 0, 0, 1, 1, 0, 5'b10100);
    add("after_miss_rv", 1, 2, 1, 0, 0, 0, 1, 0, 5'b10000);
    // DRAIN outranks load-use
    add("miss4",         1, 2, 1, 0, 0, 0, 0, 0, 5'b00100);
    add("miss_redir2",   1, 2, 1, 0, 0, 1, 0, 0, 5'b10100);
    add("drain_vs_lu",   5, 2, 1, 1, 5, 0, 1, 0, 5'b00100);
    add("lu_post_drain", 5, 2, 1, 1, 5, 0, 1, 0, 5'b01010);
    add("lu_post_once",  5, 2, 1, 1, 5, 0, 1, 0, 5'b10000);
    add("clear1",        1, 2, 1, 0, 0, 0, 1, 0, 5'b10000);
    // Load-use outranks redirect
    add("lu_vs_redir",   5, 2, 1, 1, 5, 1, 1, 0, 5'b01010);
    add("redir_retry",   5, 2, 1, 1, 5, 1, 1, 0, 5'b10100);
    add("clear2",        1, 2, 1, 0, 0, 0, 1, 0, 5'b10000);
    // dmem busy together with load-use
    add("busy_lu1",      5, 2, 1, 1, 5, 0, 1, 1, 5'b01001);
    add("busy_lu2",      5, 2, 1, 1, 5, 0, 1, 1, 5'b01001);
    add("busy_lu3",      5, 2, 1, 1, 5, 0, 1, 1, 5'b01001);
    add("busy_lu4",      5, 2, 1, 1, 5, 0, 1, 1, 5'b01001);
    add("lu_post_busy",  5, 2, 1, 1, 5, 0, 1, 0, 5'b01010);
    add("lu_busy_once",  5, 2, 1, 1, 5, 0, 1, 0, 5'b10000);
    add("clear3",        1, 2, 1, 0, 0, 0, 1, 0, 5'b10000);
    // Busy keeps DRAIN, busy outranks redirect
    add("miss5",         1, 2, 1, 0, 0, 0, 0, 0, 5'b00100);
    add("miss_redir3",   1, 2, 1, 0, 0, 1, 0, 0, 5'b10100);
    add("busy_drain",    1, 2, 1, 0, 0, 0, 1, 1, 5'b01001);
    add("drain_done2",   1, 2, 1, 0, 0, 0, 1, 0, 5'b00100);
    add("drain_run2",    1, 2, 1, 0, 0, 0, 1, 0, 5'b10000);
    add("busy_redir",    1, 2, 1, 0, 0, 1, 1, 1, 5'b01001);
    add("clear4",        1, 2, 1, 0, 0, 0, 1, 0, 5'b10000);

    // Reset state
    rst_i = 1'b0;
    set_simple(1'b0, 1'b1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outs("reset");

    @(posedge clk_i); #1;
    rst_i = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk_i); #1;
      drive(vecs[i]);
      @(negedge clk_i);
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      if (!vecs[i].exp[4]) stall_m++;
      if (vecs[i].exp[2])  flush_m++;
    end

    @(posedge clk_i); #1;
    set_simple(1'b0, 1'b1);
    @(negedge clk_i);
    check_counters("table");

    // Fresh reset, then a 20-cycle fetch stall
    #2 rst_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    set_simple(1'b0, 1'b0);
    stall_m = 0;
    flush_m = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      stall_m++;
      flush_m++;
      if (k == 5 || k == 20) check_counters($sformatf("stall%0d", k));
    end

    // Asynchronous reset mid-stall (state IMISS)
    #2 rst_i = 1'b0;
    #1 check_reset_outs("reset_mid_imiss");
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    set_simple(1'b1, 1'b0);
    @(negedge clk_i);
    check("post_reset_redir", 32'(outs()), 32'(5'b10100));
    @(posedge clk_i); #1;
    set_simple(1'b0, 1'b1);
    @(negedge clk_i);
    check("post_reset_run", 32'(outs()), 32'(5'b10000));

    // Asynchronous reset mid-DRAIN
    @(posedge clk_i); #1;
    set_simple(1'b0, 1'b0);
    @(posedge clk_i); #1;
    set_simple(1'b1, 1'b0);
    @(negedge clk_i);
    check("enter_drain", 32'(outs()), 32'(5'b10100));
    @(posedge clk_i); #1;
    set_simple(1'b0, 1'b0);
    @(negedge clk_i);
    check("in_drain", 32'(outs()), 32'(5'b00100));
    #2 rst_i = 1'b0;
    #1 check_reset_outs("reset_mid_drain");
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    set_simple(1'b0, 1'b1);
    @(negedge clk_i);
    check("drain_reset_run", 32'(outs()), 32'(5'b10000));

    @(posedge clk_i); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
